// File: rtl/fp_norm_round.sv
// Post-ALU normalizer: shifts the raw mantissa one place per cycle, rounds to
// nearest-even and packs an IEEE-754 single-precision result.
module fp_norm_round #(
  parameter int MANT_W = 27,
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [MANT_W-1:0]       mantissa_in,
  input  logic                    carry_in,
  input  logic                    sign_in,
  input  logic [EXP_W-1:0]        exp_in,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    done,
  output logic                    busy,
  output logic                    overflow,
  output logic                    underflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [27:0] m_q, m_d;
  logic [9:0]  e_q, e_d;
  logic        s_q, s_d;
  logic [31:0] result_q, result_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;

  logic        up_s;
  logic [27:0] sum_s;
  logic [27:0] m_r_s;
  logic [9:0]  e_r_s;

  // Packing happens on the final NORM/ROUND cycle, so done rises as busy falls.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    e_d      = e_q;
    s_d      = s_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    up_s  = m_q[2] & (m_q[1] | m_q[0] | m_q[3]);
    sum_s = m_q + {24'd0, up_s, 3'd0};
    if (sum_s[27]) begin
      m_r_s = {1'b0, sum_s[27:1]};
      e_r_s = e_q + 10'd1;
    end else begin
      m_r_s = sum_s;
      e_r_s = e_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = {carry_in, mantissa_in};
          e_d     = {2'b00, exp_in};
          s_d     = sign_in;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_NORM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_NORM: begin
        if (m_q == 28'd0) begin
          result_d = 32'h0000_0000;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else if (m_q[27]) begin
          m_d     = {1'b0, m_q[27:2], m_q[1] | m_q[0]};
          e_d     = e_q + 10'd1;
          state_d = S_ROUND;
        end else if (m_q[26]) begin
          state_d = S_ROUND;
        end else if (e_q <= 10'd1) begin
          result_d = {s_q, 31'd0};
          unf_d    = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end else begin
          m_d = {m_q[26:0], 1'b0};
          e_d = e_q - 10'd1;
        end
      end
      S_ROUND: begin
        m_d = m_r_s;
        e_d = e_r_s;
        if (e_r_s >= 10'd255) begin
          result_d = {s_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else begin
          result_d = {s_q, e_r_s[7:0], m_r_s[25:3]};
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      m_q      <= 28'd0;
      e_q      <= 10'd0;
      s_q      <= 1'b0;
      result_q <= 32'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      e_q      <= e_d;
      s_q      <= s_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign result    = result_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
